// File: rtl/multicycle_control_fsm.sv
// Moore controller for the shared multicycle MIPS datapath.
// State register, wait counter and event pulses live in one always_ff;
// datapath controls are decoded from the current state, with IRWrite/PCEn
// in FETCH qualified by the memory handshake.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       MemtoReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t        st, nxt;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  logic          abort;
  logic          bad_op;
  logic          funct_ok;
  logic [2:0]    alu_f;

  // A timeout only counts when the handshake is absent in the same cycle.
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == TO_VAL);
  assign state       = st;

  // R-type function decode.
  always_comb begin
    funct_ok = 1'b1;
    alu_f    = 3'b010;
    case (Funct)
      6'b100000: alu_f = 3'b010;
      6'b100010: alu_f = 3'b110;
      6'b100100: alu_f = 3'b000;
      6'b100101: alu_f = 3'b001;
      6'b101010: alu_f = 3'b111;
      default:   funct_ok = 1'b0;
    endcase
  end

  // Next-state selection, including timeout aborts and illegal decodes.
  always_comb begin
    nxt    = st;
    abort  = 1'b0;
    bad_op = 1'b0;
    case (st)
      FETCH: begin
        if (mem_ready)        nxt = DECODE;
        else if (timeout_hit) begin nxt = FETCH; abort = 1'b1; end
      end
      DECODE: begin
        case (opCode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXEC;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default:      begin nxt = FETCH; bad_op = 1'b1; end
        endcase
      end
      MEMADR: nxt = (opCode == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (mem_ready)        nxt = MEMWB;
        else if (timeout_hit) begin nxt = FETCH; abort = 1'b1; end
      end
      MEMWB: nxt = FETCH;
      MEMWR: begin
        if (mem_ready)        nxt = FETCH;
        else if (timeout_hit) begin nxt = FETCH; abort = 1'b1; end
      end
      EXEC: begin
        if (funct_ok) nxt = ALUWB;
        else begin nxt = FETCH; bad_op = 1'b1; end
      end
      ALUWB:  nxt = FETCH;
      BRANCH: nxt = FETCH;
      ADDIEX: nxt = ADDIWB;
      ADDIWB: nxt = FETCH;
      JUMP:   nxt = FETCH;
      default: nxt = FETCH;
    endcase
  end

  // State register, wait counter (restarts on every state entry, including
  // an abort back into FETCH) and registered one-cycle event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= FETCH;
      wait_cnt   <= '0;
      illegal_op <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      st         <= nxt;
      illegal_op <= bad_op;
      mem_err    <= abort;
      if (nxt != st || abort) wait_cnt <= '0;
      else if (!mem_ready)    wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Moore decode of the datapath controls; unlisted controls stay 0.
  always_comb begin
    mem_req    = 1'b0;
    memWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    regWrite   = 1'b0;
    regDst     = 1'b0;
    MemtoReg   = 1'b0;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'b00;
    ALUControl = 3'b000;
    PCSrc      = 2'b00;
    PCEn       = 1'b0;
    case (st)
      FETCH: begin
        mem_req    = 1'b1;
        aluSrcB    = 2'b01;
        ALUControl = 3'b010;
        IRWrite    = mem_ready;
        PCEn       = mem_ready;
      end
      DECODE: begin
        aluSrcB    = 2'b11;
        ALUControl = 3'b010;
      end
      MEMADR, ADDIEX: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'b10;
        ALUControl = 3'b010;
      end
      MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        regWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        memWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        aluSrcA    = 1'b1;
        ALUControl = alu_f;
      end
      ALUWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      BRANCH: begin
        aluSrcA    = 1'b1;
        ALUControl = 3'b110;
        PCSrc      = 2'b01;
        PCEn       = Zero;
      end
      ADDIWB: regWrite = 1'b1;
      JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
